// File: rtl/kernel_window_cfg_if.sv
// Pixel-stream input and window-output bundle for kernel_window_cfg.
// The master drives pixels and control; the slave returns windows.
interface kernel_window_cfg_if #(
    parameter int DATA_WIDHT = 32,
    parameter int KSIZE      = 3
);
    logic [DATA_WIDHT-1:0]             Data_In;
    logic                              Valid_in;
    logic [1:0]                        Stride;
    logic                              Clr;
    logic [KSIZE*KSIZE*DATA_WIDHT-1:0] Window_Out;
    logic                              Valid_Out;
    logic                              Frame_Done;

    modport master (
        output Data_In, Valid_in, Stride, Clr,
        input  Window_Out, Valid_Out, Frame_Done
    );

    modport slave (
        input  Data_In, Valid_in, Stride, Clr,
        output Window_Out, Valid_Out, Frame_Done
    );
endinterface

// File: rtl/kernel_window_cfg.sv
// Sliding KSIZE x KSIZE window generator over a raster pixel stream, with a
// per-frame stride and line buffers holding the previous KSIZE-1 rows.
module kernel_window_cfg #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDHT  = 220,
    parameter int IMG_HEIGHT = 220,
    parameter int KSIZE      = 3
) (
    input  logic                clk,
    input  logic                rst,
    kernel_window_cfg_if.slave  bus
);

    localparam int CW  = $clog2(IMG_WIDHT);
    localparam int RW  = $clog2(IMG_HEIGHT);
    localparam int NLB = KSIZE - 1;
    localparam int WW  = KSIZE * KSIZE * DATA_WIDHT;

    localparam logic [CW-1:0] C_LAST   = CW'(IMG_WIDHT - 1);
    localparam logic [RW-1:0] R_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] C_KFIRST = CW'(KSIZE - 1);
    localparam logic [RW-1:0] R_KFIRST = RW'(KSIZE - 1);

    typedef logic [DATA_WIDHT-1:0] pix_t;

    // Phases count modulo the latched stride; s is always 1..3.
    function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic [1:0] s);
        return (ph == s - 2'd1) ? 2'd0 : ph + 2'd1;
    endfunction

    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    logic [1:0]    s_q, s_d;
    logic [1:0]    cph_q, cph_d;
    logic [1:0]    rph_q, rph_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic [WW-1:0] wout_q, wout_d;

    pix_t lb_q  [NLB][IMG_WIDHT];
    pix_t lb_d  [NLB][IMG_WIDHT];
    pix_t win_q [KSIZE][KSIZE];
    pix_t win_d [KSIZE][KSIZE];
    pix_t win_sh[KSIZE][KSIZE];

    logic          acc;
    logic          c_end;
    logic          r_end;
    logic          first_px;
    logic          emit;
    logic [1:0]    eff_stride;
    logic [CW-1:0] c_nxt;
    logic [RW-1:0] r_nxt;
    logic [WW-1:0] wout_sh;

    assign acc        = bus.Valid_in & ~bus.Clr;
    assign c_end      = (c_q == C_LAST);
    assign r_end      = (r_q == R_LAST);
    assign first_px   = (c_q == '0) && (r_q == '0);
    assign eff_stride = (bus.Stride == 2'd0) ? 2'd1 : bus.Stride;
    assign c_nxt      = c_end ? '0 : c_q + 1'b1;
    assign r_nxt      = c_end ? (r_end ? '0 : r_q + 1'b1) : r_q;
    assign emit       = acc && (c_q >= C_KFIRST) && (r_q >= R_KFIRST)
                        && (cph_q == 2'd0) && (rph_q == 2'd0);

    // Phases are pinned to 0 until the first full window position, so the
    // bottom-right pixel at column/row KSIZE-1 always starts a stride period.
    always_comb begin
        c_d    = c_q;
        r_d    = r_q;
        s_d    = s_q;
        cph_d  = cph_q;
        rph_d  = rph_q;
        vld_d  = 1'b0;
        done_d = 1'b0;
        if (bus.Clr) begin
            c_d   = '0;
            r_d   = '0;
            s_d   = 2'd1;
            cph_d = 2'd0;
            rph_d = 2'd0;
        end else if (bus.Valid_in) begin
            c_d   = c_nxt;
            r_d   = r_nxt;
            if (first_px) s_d = eff_stride;
            cph_d = (c_nxt <= C_KFIRST) ? 2'd0 : phase_step(cph_q, s_q);
            if (c_end) rph_d = (r_nxt <= R_KFIRST) ? 2'd0 : phase_step(rph_q, s_q);
            vld_d  = emit;
            done_d = c_end && r_end;
        end
    end

    // Window shifts left by one column; the new right column is the stored
    // rows at this column (oldest on top) plus the incoming pixel.
    always_comb begin
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE - 1; j++) begin
                win_sh[i][j] = win_q[i][j+1];
            end
        end
        for (int i = 0; i < KSIZE - 1; i++) begin
            win_sh[i][KSIZE-1] = lb_q[KSIZE-2-i][c_q];
        end
        win_sh[KSIZE-1][KSIZE-1] = bus.Data_In;

        wout_sh = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                wout_sh[(i*KSIZE+j)*DATA_WIDHT +: DATA_WIDHT] = win_sh[i][j];
            end
        end
    end

    always_comb begin
        lb_d   = lb_q;
        win_d  = win_q;
        wout_d = wout_q;
        if (acc) begin
            lb_d[0][c_q] = bus.Data_In;
            for (int k = 1; k < NLB; k++) begin
                lb_d[k][c_q] = lb_q[k-1][c_q];
            end
            win_d = win_sh;
        end
        if (emit) wout_d = wout_sh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q    <= '0;
            r_q    <= '0;
            s_q    <= 2'd1;
            cph_q  <= 2'd0;
            rph_q  <= 2'd0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            wout_q <= '0;
        end else begin
            c_q    <= c_d;
            r_q    <= r_d;
            s_q    <= s_d;
            cph_q  <= cph_d;
            rph_q  <= rph_d;
            vld_q  <= vld_d;
            done_q <= done_d;
            wout_q <= wout_d;
        end
    end

    // Pixel storage needs no reset: windows only form after KSIZE-1 fresh rows.
    always_ff @(posedge clk) begin
        lb_q  <= lb_d;
        win_q <= win_d;
    end

    assign bus.Window_Out = wout_q;
    assign bus.Valid_Out  = vld_q;
    assign bus.Frame_Done = done_q;

endmodule

// File: tb/tb_kernel_window_cfg.sv
// Directed bench for kernel_window_cfg: an 8x6 KSIZE=3 instance and an 8x7
// KSIZE=5 instance, checked against hand-computed windows and counts.
module tb_kernel_window_cfg;

    logic clk;
    logic rst;

    kernel_window_cfg_if #(.DATA_WIDHT(32), .KSIZE(3)) bus3 ();
    kernel_window_cfg_if #(.DATA_WIDHT(32), .KSIZE(5)) bus5 ();

    kernel_window_cfg #(
        .DATA_WIDHT(32), .IMG_WIDHT(8), .IMG_HEIGHT(6), .KSIZE(3)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    kernel_window_cfg #(
        .DATA_WIDHT(32), .IMG_WIDHT(8), .IMG_HEIGHT(7), .KSIZE(5)
    ) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_win[9];
    int dut_log[32][9];
    int n_dut;
    int lit[9];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_window(input string tag);
        for (int e = 0; e < 9; e++)
            check_val($sformatf("%s_e%0d", tag, e), bus3.Window_Out[e*32 +: 32], exp_win[e]);
    endtask

    task automatic log_dut();
        if (bus3.Valid_Out === 1'b1) begin
            if (n_dut < 32)
                for (int e = 0; e < 9; e++) dut_log[n_dut][e] = int'(bus3.Window_Out[e*32 +: 32]);
            n_dut++;
        end
    endtask

    task automatic check_logged(input string tag, input int idx);
        for (int e = 0; e < 9; e++)
            check_val($sformatf("%s_e%0d", tag, e), dut_log[idx][e], lit[e]);
    endtask

    // Sends pixels 0..n_pix-1 of a frame (value = r*8+c) and checks every cycle.
    task automatic run_frame(input int n_pix, input logic [1:0] s0, input logic [1:0] s1,
                             input int chg_at, input bit gaps);
        int  s_frm, r, c, n_idle;
        bit  emit;
        s_frm = (s0 == 2'd0) ? 1 : int'(s0);
        n_dut = 0;
        for (int p = 0; p < n_pix; p++) begin
            n_idle = gaps ? int'($urandom_range(2, 0)) : 0;
            repeat (n_idle) begin
                bus3.Valid_in = 1'b0;
                bus3.Data_In  = 32'hDEAD_BEEF;
                @(posedge clk); #1;
                log_dut();
                check_val("gap_vld", bus3.Valid_Out, 0);
                check_val("gap_done", bus3.Frame_Done, 0);
                check_window("gap_hold");
            end
            bus3.Valid_in = 1'b1;
            bus3.Data_In  = p;
            bus3.Stride   = (p < chg_at) ? s0 : s1;
            @(posedge clk); #1;
            log_dut();
            r = p / 8;
            c = p % 8;
            emit = (r >= 2) && (c >= 2) && ((r - 2) % s_frm == 0) && ((c - 2) % s_frm == 0);
            if (emit)
                for (int e = 0; e < 9; e++) exp_win[e] = (r - 2 + e / 3) * 8 + (c - 2 + e % 3);
            check_val($sformatf("vld_p%0d", p), bus3.Valid_Out, emit);
            check_val($sformatf("done_p%0d", p), bus3.Frame_Done, p == 47);
            check_window($sformatf("win_p%0d", p));
        end
        bus3.Valid_in = 1'b0;
    endtask

    initial begin
        int n5;
        clk = 1'b0;
        rst = 1'b0;
        bus3.Data_In = '0; bus3.Valid_in = 1'b0; bus3.Stride = 2'd1; bus3.Clr = 1'b0;
        bus5.Data_In = '0; bus5.Valid_in = 1'b0; bus5.Stride = 2'd0; bus5.Clr = 1'b0;
        for (int e = 0; e < 9; e++) exp_win[e] = 0;

        #12;
        check_val("rst_vld", bus3.Valid_Out, 0);
        check_val("rst_done", bus3.Frame_Done, 0);
        check_window("rst_win");
        check_val("rst_vld5", bus5.Valid_Out, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Stride 1, continuous
        run_frame(48, 2'd1, 2'd1, 99, 1'b0);
        check_val("s1_count", n_dut, 24);
        lit = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        check_logged("s1_first", 0);

        // Stride 1 -> 2 at pixel 20 applies only to the next frame
        run_frame(48, 2'd1, 2'd2, 20, 1'b0);
        check_val("chg_count", n_dut, 24);
        run_frame(48, 2'd2, 2'd2, 99, 1'b0);
        check_val("s2_count", n_dut, 6);
        lit = '{2, 3, 4, 10, 11, 12, 18, 19, 20};
        check_logged("s2_second", 1);
        lit = '{20, 21, 22, 28, 29, 30, 36, 37, 38};
        check_logged("s2_last", 5);

        // Stride 3 with random input gaps
        run_frame(48, 2'd3, 2'd3, 99, 1'b1);
        check_val("s3_count", n_dut, 4);
        lit = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        check_logged("s3_first", 0);
        lit = '{27, 28, 29, 35, 36, 37, 43, 44, 45};
        check_logged("s3_last", 3);

        // Reset asserted mid-frame, right after pixel 30 produced a window
        run_frame(31, 2'd1, 2'd1, 99, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        for (int e = 0; e < 9; e++) exp_win[e] = 0;
        check_val("mid_rst_vld", bus3.Valid_Out, 0);
        check_val("mid_rst_done", bus3.Frame_Done, 0);
        check_window("mid_rst_win");
        @(posedge clk); #1;
        rst = 1'b1;
        run_frame(48, 2'd1, 2'd1, 99, 1'b0);
        check_val("post_rst_count", n_dut, 24);
        lit = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        check_logged("post_rst_first", 0);

        // Clr beats Valid_in on a pixel that would otherwise complete a window
        run_frame(18, 2'd1, 2'd1, 99, 1'b0);
        bus3.Clr = 1'b1; bus3.Valid_in = 1'b1; bus3.Data_In = 32'd18;
        @(posedge clk); #1;
        check_val("clr_vld", bus3.Valid_Out, 0);
        check_val("clr_done", bus3.Frame_Done, 0);
        bus3.Clr = 1'b0; bus3.Valid_in = 1'b0;
        run_frame(48, 2'd1, 2'd1, 99, 1'b0);
        check_val("post_clr_count", n_dut, 24);
        check_logged("post_clr_first", 0);

        // KSIZE=5, Stride=0 treated as 1, 8x7 frame
        n5 = 0;
        for (int p = 0; p < 56; p++) begin
            bus5.Valid_in = 1'b1;
            bus5.Data_In  = p;
            bus5.Stride   = 2'd0;
            @(posedge clk); #1;
            if (bus5.Valid_Out === 1'b1) n5++;
            check_val($sformatf("k5_vld_p%0d", p), bus5.Valid_Out, (p / 8 >= 4) && (p % 8 >= 4));
            check_val($sformatf("k5_done_p%0d", p), bus5.Frame_Done, p == 55);
            if (p == 36) begin
                check_val("k5_first_e0", bus5.Window_Out[0 +: 32], 0);
                check_val("k5_first_e12", bus5.Window_Out[12*32 +: 32], 18);
                check_val("k5_first_e24", bus5.Window_Out[24*32 +: 32], 36);
            end
        end
        bus5.Valid_in = 1'b0;
        check_val("k5_count", n5, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
